bram2_be: RTL and testbench

Single-clock, true-dual-port block RAM model with per-byte write enables, a selectable same-port read-during-write mode, deterministic write/write collision resolution, output-valid strobes and an optional post-reset clear sweep. It is the generalised successor to the existing dual-port write-first BRAM wrapper. It serves as the backing store for caches, register files and scratchpads where byte-granular stores and a known-zero start state are required.

---
 rtl/bram_pkg.sv | 29 ++
 rtl/bram_clr_seq.sv | 50 +++++
 rtl/bram2_be.sv | 135 +++++++++++++
 tb/tb_bram2_be.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enable dual-port BRAM: write-mode codes, clear FSM states, lane merge.
package bram_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate around it.
  localparam int MERGE_W = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] en,
    input int                 chunk
  );
    logic [MERGE_W-1:0] m;
    for (int i = 0; i < MERGE_W; i++) begin
      m[i] = en[i / chunk] ? new_w[i] : old_w[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/bram_clr_seq.sv
// Post-reset clear sequencer: walks every word address once, then raises rdy.
module bram_clr_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MEMSIZE    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rdy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEMSIZE - 1);

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy       = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end
      end
      ST_READY: rdy = 1'b1;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/bram2_be.sv
// True-dual-port byte-enable BRAM with selectable read-during-write mode and optional output register.
// Define BRAM_CLEAR_ON_RESET_EN to zero the array after reset (RDY held low during the sweep).
module bram2_be
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CHUNKSIZE  = 8,
  parameter int WE_WIDTH   = DATA_WIDTH / CHUNKSIZE,
  parameter int MEMSIZE    = 1024,
  parameter int PIPELINED  = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  RDY,
  input  logic                  ENA,
  input  logic [WE_WIDTH-1:0]   WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [WE_WIDTH-1:0]   WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID,
  output logic                  COLLISION
);

  localparam int                  IW    = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEMSIZE);

  logic [DATA_WIDTH-1:0] mem [MEMSIZE];

  logic                  rdy_i, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CLEAR_ON_RESET_EN
  bram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH), .MEMSIZE(MEMSIZE)) u_clr_seq (
    .clk(CLK), .rst(RST), .rdy(rdy_i), .clr_addr(clr_addr), .clr_we(clr_we)
  );
`else
  always_ff @(posedge CLK) rdy_i <= ~RST;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif
  assign RDY = rdy_i;

  logic                  acc_a, acc_b, in_a, in_b, wr_a, wr_b, same;
  logic [IW-1:0]         idx_a, idx_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, mrg_ab;
  logic                  v1a_n, v1b_n, col_n;
  logic [DATA_WIDTH-1:0] d1a_n, d1b_n;

  always_comb begin
    acc_a  = ENA && rdy_i && !RST;
    acc_b  = ENB && rdy_i && !RST;
    in_a   = {1'b0, ADDRA} < LIMIT;
    in_b   = {1'b0, ADDRB} < LIMIT;
    idx_a  = ADDRA[IW-1:0];
    idx_b  = ADDRB[IW-1:0];
    old_a  = mem[idx_a];
    old_b  = mem[idx_b];
    wr_a   = acc_a && (|WEA) && in_a;
    wr_b   = acc_b && (|WEB) && in_b;
    same   = (ADDRA == ADDRB);
    mrg_a  = DATA_WIDTH'(byte_merge(MERGE_W'(old_a), MERGE_W'(DIA), MERGE_W'(WEA), CHUNKSIZE));
    mrg_b  = DATA_WIDTH'(byte_merge(MERGE_W'(old_b), MERGE_W'(DIB), MERGE_W'(WEB), CHUNKSIZE));
    // Same-word double write: B lanes land first so A overrides any overlap.
    mrg_ab = DATA_WIDTH'(byte_merge(MERGE_W'(mrg_b), MERGE_W'(DIA), MERGE_W'(WEA), CHUNKSIZE));
    col_n  = wr_a && wr_b && same && (|(WEA & WEB));

    v1a_n  = acc_a && !((|WEA) && (WRITE_MODE == WM_NO_CHANGE));
    v1b_n  = acc_b && !((|WEB) && (WRITE_MODE == WM_NO_CHANGE));
    d1a_n  = !in_a ? '0 : ((|WEA) && (WRITE_MODE == WM_WRITE_FIRST)) ? mrg_a : old_a;
    d1b_n  = !in_b ? '0 : ((|WEB) && (WRITE_MODE == WM_WRITE_FIRST)) ? mrg_b : old_b;
  end

  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_addr[IW-1:0]] <= '0;
    if (wr_b && !(wr_a && same)) mem[idx_b] <= mrg_b;
    if (wr_a) mem[idx_a] <= (wr_b && same) ? mrg_ab : mrg_a;
  end

  logic                  v1a, v1b;
  logic [DATA_WIDTH-1:0] d1a, d1b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1a       <= 1'b0;
      v1b       <= 1'b0;
      d1a       <= '0;
      d1b       <= '0;
      COLLISION <= 1'b0;
    end else begin
      v1a       <= v1a_n;
      v1b       <= v1b_n;
      COLLISION <= col_n;
      if (v1a_n) d1a <= d1a_n;
      if (v1b_n) d1b <= d1b_n;
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic                  v2a, v2b;
      logic [DATA_WIDTH-1:0] d2a, d2b;
      always_ff @(posedge CLK) begin
        if (RST) begin
          v2a <= 1'b0;
          v2b <= 1'b0;
          d2a <= '0;
          d2b <= '0;
        end else begin
          v2a <= v1a;
          v2b <= v1b;
          if (v1a) d2a <= d1a;
          if (v1b) d2b <= d1b;
        end
      end
      assign DOA = d2a;
      assign DOB = d2b;
      assign DOA_VALID = v2a;
      assign DOB_VALID = v2b;
    end else begin : g_flat
      assign DOA = d1a;
      assign DOB = d1b;
      assign DOA_VALID = v1a;
      assign DOB_VALID = v1b;
    end
  endgenerate

endmodule

// File: tb/tb_bram2_be.sv
// Scoreboard bench: three bram2_be variants (WF/P0, RF/P1, NC/P0) share stimulus against a lane-level memory model.
module tb_bram2_be;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MS = 16;
  localparam int NI = 3;
`ifdef BRAM_CLEAR_ON_RESET_EN
  localparam int CLR_CYC = MS;
`else
  localparam int CLR_CYC = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0, enb = 1'b0;
  logic [3:0]    wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dia = '0, dib = '0;

  logic          rdy [NI];
  logic [DW-1:0] doa [NI];
  logic [DW-1:0] dob [NI];
  logic          vla [NI];
  logic          vlb [NI];
  logic          col [NI];

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      bram2_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(8), .MEMSIZE(MS),
        .PIPELINED(k == 1 ? 1 : 0), .WRITE_MODE(k)
      ) u_dut (
        .CLK(clk), .RST(rst), .RDY(rdy[k]),
        .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[k]), .DOA_VALID(vla[k]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[k]), .DOB_VALID(vlb[k]),
        .COLLISION(col[k])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  typedef struct {
    logic [31:0] d;
    int          due;
    bit          dc;
  } exp_t;

  exp_t        q [2*NI][$];
  logic [31:0] last [2*NI];
  bit          last_ok [2*NI];
  logic [31:0] mdl [MS];
  bit          known [MS];
  bit          col_at [int];
  int          mclr = -1;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic void chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cycle %0d: got %h, want %h", name, idx, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] lane_merge(logic [31:0] old, logic [31:0] nw, logic [3:0] we);
    logic [31:0] r = old;
    for (int l = 0; l < 4; l++) if (we[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  // Expected response of instance k (0: write-first, 1: read-first + output reg, 2: no-change).
  function automatic void expect_port(int i, int k, logic [3:0] we, logic [AW-1:0] a, logic [31:0] di);
    exp_t        e;
    bit          inr  = int'(a) < MS;
    logic [31:0] old  = inr ? mdl[a[3:0]] : 32'h0;
    bit          oldk = inr ? known[a[3:0]] : 1'b1;
    e.due = cyc + 1 + (k == 1 ? 1 : 0);
    if (we == 4'h0 || k == 1) begin
      e.d = old; e.dc = !oldk; q[i].push_back(e);
    end else if (k == 0) begin
      e.d  = inr ? lane_merge(old, di, we) : 32'h0;
      e.dc = inr && !(oldk || we == 4'hF);
      q[i].push_back(e);
    end
  endfunction

  function automatic void mem_write(logic [3:0] we, logic [AW-1:0] a, logic [31:0] di);
    if (int'(a) < MS) begin
      mdl[a[3:0]]   = lane_merge(mdl[a[3:0]], di, we);
      known[a[3:0]] = known[a[3:0]] || (we == 4'hF);
    end
  endfunction

  task automatic op(input bit r,
                    input bit ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [31:0] da,
                    input bit eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [31:0] db);
    bit acc_a, acc_b;
    rst = r; ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    if (mclr >= 0) for (int k = 0; k < NI; k++) chk("rdy", k, 32'(rdy[k]), 32'(mclr == 0));
    acc_a = ea && !r && (mclr == 0);
    acc_b = eb && !r && (mclr == 0);
    for (int k = 0; k < NI; k++) begin
      if (acc_a) expect_port(2*k, k, wa, aa, da);
      if (acc_b) expect_port(2*k+1, k, wb, ab, db);
    end
    if (acc_a && acc_b && wa != 0 && wb != 0 && aa == ab && int'(aa) < MS && (wa & wb) != 0)
      col_at[cyc+1] = 1'b1;
    if (acc_b && wb != 0) mem_write(wb, ab, db);
    if (acc_a && wa != 0) mem_write(wa, aa, da);
    if (r) begin
      for (int i = 0; i < 2*NI; i++)
        while (q[i].size() > 0 && q[i][$].due > cyc) void'(q[i].pop_back());
    end
    @(posedge clk);
    #1;
    if (r) begin
      mclr = CLR_CYC;
`ifdef BRAM_CLEAR_ON_RESET_EN
      for (int a = 0; a < MS; a++) begin mdl[a] = 32'h0; known[a] = 1'b1; end
`endif
    end else if (mclr > 0) begin
      mclr--;
    end
  endtask

  task automatic op_idle(input bit r);
    op(r, 0, 4'h0, '0, 32'h0, 0, 4'h0, '0, 32'h0);
  endtask

  function automatic logic [3:0] rnd_we();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 19));
  endfunction

  task automatic op_rand();
    op(0, bit'($urandom_range(0, 1)), rnd_we(), rnd_addr(), $urandom(),
          bit'($urandom_range(0, 1)), rnd_we(), rnd_addr(), $urandom());
  endtask

  function automatic void mon_port(int i, logic v, logic [31:0] d);
    exp_t e;
    bit   ev;
    if (rst_seen) begin
      chk("rst_valid", i, 32'(v), 32'h0);
      chk("rst_data", i, d, 32'h0);
      last[i] = 32'h0; last_ok[i] = 1'b1;
      return;
    end
    ev = q[i].size() > 0 && q[i][0].due <= cyc;
    chk("valid", i, 32'(v), 32'(ev));
    if (ev) begin
      e = q[i].pop_front();
      if (v) begin
        if (!e.dc) chk("data", i, d, e.d);
        last[i] = e.d; last_ok[i] = !e.dc;
      end
    end else if (!v && last_ok[i]) begin
      chk("hold", i, d, last[i]);
    end
  endfunction

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < NI; k++) begin
        mon_port(2*k, vla[k], doa[k]);
        mon_port(2*k+1, vlb[k], dob[k]);
        chk("collision", k, 32'(col[k]), 32'(col_at.exists(cyc)));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    repeat (2) op_idle(1);
    while (mclr > 0) op_rand();
`ifdef BRAM_CLEAR_ON_RESET_EN
    op(0, 1, 4'h0, 5'd5, 32'h0, 1, 4'h0, 5'd5, 32'h0);
    op_idle(1);
    repeat (8) op_rand();
    op_idle(1);
    while (mclr > 0) op_rand();
`endif
    for (int a = 0; a < MS; a++) op(0, 1, 4'hF, AW'(a), $urandom(), 0, 4'h0, '0, 32'h0);

    // byte-enable merge
    op(0, 1, 4'hF, 5'd3, 32'h11223344, 0, 4'h0, '0, 32'h0);
    op(0, 1, 4'h5, 5'd3, 32'hAABBCCDD, 0, 4'h0, '0, 32'h0);
    op(0, 1, 4'h0, 5'd3, 32'h0, 1, 4'h0, 5'd3, 32'h0);
    // write/write collision with partial overlap
    op(0, 1, 4'hF, 5'd7, 32'h0, 0, 4'h0, '0, 32'h0);
    op(0, 1, 4'h3, 5'd7, 32'hAAAAAAAA, 1, 4'h6, 5'd7, 32'hBBBBBBBB);
    op(0, 1, 4'h0, 5'd7, 32'h0, 1, 4'h0, 5'd7, 32'h0);
    op_idle(0);
    // same-port read-during-write per mode
    op(0, 1, 4'hF, 5'd2, 32'h0, 0, 4'h0, '0, 32'h0);
    op(0, 1, 4'hF, 5'd2, 32'h12345678, 0, 4'h0, '0, 32'h0);
    op_idle(0);
    // cross-port read of a word being written
    op(0, 1, 4'hF, 5'd9, 32'h0, 0, 4'h0, '0, 32'h0);
    op(0, 1, 4'hF, 5'd9, 32'hCAFEF00D, 1, 4'h0, 5'd9, 32'h0);
    op(0, 0, 4'h0, '0, 32'h0, 1, 4'h0, 5'd9, 32'h0);
    // out-of-range accesses
    op(0, 1, 4'hF, 5'd20, 32'hDEADBEEF, 1, 4'h0, 5'd20, 32'h0);
    op(0, 1, 4'h0, 5'd17, 32'h0, 1, 4'hF, 5'd31, 32'h55555555);

    repeat (400) op_rand();

    // reset one cycle after a read: the registered-output variant must drop it
    op(0, 1, 4'h0, 5'd3, 32'h0, 1, 4'h0, 5'd1, 32'h0);
    op_idle(1);
    while (mclr > 0) op_rand();
    repeat (100) op_rand();
    repeat (4) op_idle(0);

    for (int i = 0; i < 2*NI; i++) chk("drain", i, 32'(q[i].size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
